// File: rtl/mult_pkg.sv
// Shared parameters and width helpers for the shift-add multiplier and its accumulator.
package mult_pkg;

    localparam int unsigned DATAWIDTH_DEFAULT = 14;
    localparam int unsigned ACC_LEN_DEFAULT   = 4;
    localparam int unsigned COUNT_W           = $clog2(ACC_LEN_DEFAULT) + 1;

    // Width that holds acc_len full-scale products without overflow.
    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned acc_len);
        return 2 * dw + $clog2(acc_len);
    endfunction

    function automatic int unsigned count_width(input int unsigned acc_len);
        return $clog2(acc_len) + 1;
    endfunction

endpackage

// File: rtl/mac_accumulator.sv
// Sums ACC_LEN consecutive product strobes and presents each block sum behind valid/ready.
// Never back-pressures the multiplier; a sum that finds the output slot full is dropped.
module mac_accumulator
    import mult_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DATAWIDTH_DEFAULT,
    parameter int unsigned ACC_LEN   = ACC_LEN_DEFAULT,
    localparam int unsigned ACCWIDTH = acc_width(DATAWIDTH, ACC_LEN),
    localparam int unsigned CW       = count_width(ACC_LEN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   prod_valid,
    input  logic [2*DATAWIDTH-1:0] product,
    input  logic                   flush,
    input  logic                   clr_overrun,
    output logic                   acc_valid,
    input  logic                   acc_ready,
    output logic [ACCWIDTH-1:0]    acc_sum,
    output logic [CW-1:0]          acc_count,
    output logic                   overrun
);

    logic [CW-1:0]       count_q, count_d;
    logic [ACCWIDTH-1:0] acc_q, acc_d;
    logic [ACCWIDTH-1:0] sum_q, sum_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;

    logic [ACCWIDTH-1:0] prod_ext;
    logic [ACCWIDTH-1:0] next_acc;
    logic                take;
    logic                complete;
    logic                slot_free;

    always_comb begin
        prod_ext  = ACCWIDTH'(product);
        // First product of a block overwrites rather than adds, so no clear cycle is needed.
        next_acc  = ((count_q == '0) ? '0 : acc_q) + prod_ext;
        take      = prod_valid && !flush;
        complete  = take && (count_q == CW'(ACC_LEN - 1));
        slot_free = !valid_q || acc_ready;
    end

    always_comb begin
        count_d   = count_q;
        acc_d     = acc_q;
        sum_d     = sum_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (flush) begin
            count_d = '0;
        end else if (prod_valid) begin
            acc_d   = next_acc;
            count_d = complete ? '0 : count_q + CW'(1);
        end

        if (valid_q && acc_ready) begin
            valid_d = 1'b0;
        end

        if (clr_overrun) begin
            overrun_d = 1'b0;
        end

        if (complete) begin
            if (slot_free) begin
                sum_d   = next_acc;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            acc_q     <= '0;
            sum_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            acc_q     <= acc_d;
            sum_q     <= sum_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign acc_valid = valid_q;
    assign acc_sum   = sum_q;
    assign acc_count = count_q;
    assign overrun   = overrun_q;

endmodule
